// File: rtl/sbox_tbox_pkg.sv
// Shared types and the combined S/T-box table for the AES column pipeline.
// Latency: n/a (types and constants only). Backpressure: n/a.
// The table is built at elaboration from GF(2^8) arithmetic, so there are no hand-typed constants to get wrong.
package sbox_tbox_pkg;

    typedef enum logic [1:0] {
        ENC_T = 2'd0,
        DEC_T = 2'd1,
        ENC_S = 2'd2,
        DEC_S = 2'd3
    } mode_e;

    typedef logic [79:0] entry_t;

    localparam int S_LSB    = 72;
    localparam int TE_LSB   = 40;
    localparam int INVS_LSB = 32;
    localparam int TD_LSB   = 0;

    typedef logic [255:0][79:0] table_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse; it also maps 0 to 0 as AES requires.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] rotr32(input logic [31:0] w, input int n);
        return (w >> n) | (w << (32 - n));
    endfunction

    // Te/Td words are the row-0 contributions; other rows are byte rotations.
    function automatic table_t build_table();
        table_t     t;
        logic [7:0] x;
        logic [7:0] s;
        t = '0;
        for (int i = 0; i < 256; i++) begin
            x = 8'(i);
            s = sbox_fwd(x);
            t[x][S_LSB +: 8]     = s;
            t[x][TE_LSB +: 32]   = {xtime(s), s, s, xtime(s) ^ s};
            t[s][INVS_LSB +: 8]  = x;
            t[s][TD_LSB +: 32]   = {gmul(x, 8'h0e), gmul(x, 8'h09),
                                    gmul(x, 8'h0d), gmul(x, 8'h0b)};
        end
        return t;
    endfunction

    localparam table_t SBOX_TBOX_TABLE = build_table();

endpackage

// File: rtl/sbox_tbox_rom.sv
// Byte -> {S, Te, InvS, Td} lookup.
// Latency: combinational. Backpressure: none (pure function).
module sbox_tbox_rom
    import sbox_tbox_pkg::*;
(
    input  logic [7:0] addr,
    output entry_t     entry
);

    assign entry = SBOX_TBOX_TABLE[addr];

endmodule

// File: rtl/sbox_tbox_pipe.sv
// Per-column SubBytes(+MixColumns) or inverse, optional AddRoundKey under SBOX_TBOX_PIPE_ARK_EN.
// Latency: 2 cycles, one beat per cycle sustained.
// Backpressure: valid/ready; stages hold while out_ready is low, in_ready drops once both are full.
module sbox_tbox_pipe
    import sbox_tbox_pkg::*;
#(
    parameter int NCOL = 4
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_mode,
    input  logic [32*NCOL-1:0]  in_data,
`ifdef SBOX_TBOX_PIPE_ARK_EN
    input  logic [32*NCOL-1:0]  in_key,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [32*NCOL-1:0]  out_data
);

    localparam int NB = 4 * NCOL;

    entry_t [NB-1:0]    rom_ent;
    entry_t [NB-1:0]    s1_ent;
    mode_e              s1_mode;
    logic               s1_vld;
    logic               s2_vld;
    logic               s1_adv;
    logic               accept;
    logic [32*NCOL-1:0] res;
    logic [32*NCOL-1:0] s2_dat;
    logic [31:0]        te_x;
    logic [31:0]        td_x;
    logic [31:0]        s_w;
    logic [31:0]        is_w;
`ifdef SBOX_TBOX_PIPE_ARK_EN
    logic [32*NCOL-1:0] s1_key;
`endif

    // Byte index 4c+r is row r of column c; row 0 is the column MSB.
    for (genvar b = 0; b < NB; b++) begin : g_rom
        sbox_tbox_rom u_rom (
            .addr  (in_data[32*(b/4) + 24 - 8*(b%4) +: 8]),
            .entry (rom_ent[b])
        );
    end

    assign s1_adv   = !s2_vld || out_ready;
    assign in_ready = !s1_vld || s1_adv;
    assign accept   = in_valid && in_ready;

    always_comb begin
        res  = '0;
        te_x = '0;
        td_x = '0;
        s_w  = '0;
        is_w = '0;
        for (int c = 0; c < NCOL; c++) begin
            te_x = '0;
            td_x = '0;
            s_w  = '0;
            is_w = '0;
            for (int r = 0; r < 4; r++) begin
                te_x = te_x ^ rotr32(s1_ent[4*c+r][TE_LSB +: 32], 8*r);
                td_x = td_x ^ rotr32(s1_ent[4*c+r][TD_LSB +: 32], 8*r);
                s_w[24-8*r +: 8]  = s1_ent[4*c+r][S_LSB +: 8];
                is_w[24-8*r +: 8] = s1_ent[4*c+r][INVS_LSB +: 8];
            end
            case (s1_mode)
                ENC_T:   res[32*c +: 32] = te_x;
                DEC_T:   res[32*c +: 32] = td_x;
                ENC_S:   res[32*c +: 32] = s_w;
                default: res[32*c +: 32] = is_w;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s2_vld  <= 1'b0;
            s1_mode <= ENC_T;
            s1_ent  <= '0;
            s2_dat  <= '0;
`ifdef SBOX_TBOX_PIPE_ARK_EN
            s1_key  <= '0;
`endif
        end else begin
            if (in_ready) s1_vld <= in_valid;
            if (accept) begin
                s1_ent  <= rom_ent;
                s1_mode <= mode_e'(in_mode);
`ifdef SBOX_TBOX_PIPE_ARK_EN
                s1_key  <= in_key;
`endif
            end
            if (s1_adv) s2_vld <= s1_vld;
            if (s1_adv && s1_vld) begin
`ifdef SBOX_TBOX_PIPE_ARK_EN
                s2_dat <= res ^ s1_key;
`else
                s2_dat <= res;
`endif
            end
        end
    end

    assign out_valid = s2_vld;
    // Zero while reset is held, not just from the edge after it.
    assign out_data  = rst ? '0 : s2_dat;

endmodule

// File: tb/tb_sbox_tbox_pipe.sv
// Directed-vector bench for sbox_tbox_pipe (NCOL=4); expected values are hand-derived AES results.
module tb_sbox_tbox_pipe;

    localparam int NCOL = 4;
    localparam int W    = 32 * NCOL;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_mode;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
`ifdef SBOX_TBOX_PIPE_ARK_EN
    logic [W-1:0] in_key;
`endif

    always #5 clk = ~clk;

    sbox_tbox_pipe #(.NCOL(NCOL)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
`ifdef SBOX_TBOX_PIPE_ARK_EN
        .in_key    (in_key),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    typedef struct {
        logic [1:0]   mode;
        logic [W-1:0] din;
        logic [W-1:0] dout;
    } vec_t;

    vec_t         vecs [8];
    logic [W-1:0] exp_q [$];
    logic [W-1:0] cur_exp;
    int           n_chk  = 0;
    int           n_fail = 0;
    int           sent;
    int           rcvd;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        in_mode  = v.mode;
        in_data  = v.din;
        cur_exp  = v.dout;
    endtask

    // One clock: score what handshakes at the coming edge, then advance.
    task automatic step(input string tag);
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL %s: unexpected result %h", tag, out_data);
            end else begin
                check({tag, "_data"}, out_data, exp_q.pop_front());
            end
            rcvd++;
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(cur_exp);
            sent++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'd0, {4{32'h01010101}}, {4{32'h7c7c7c7c}}};
        vecs[1] = '{2'd1, {4{32'h7c7c7c7c}}, {4{32'h01010101}}};
        vecs[2] = '{2'd2, {4{32'h00530000}}, {4{32'h63ed6363}}};
        vecs[3] = '{2'd3, {4{32'h63636363}}, {4{32'h00000000}}};
        vecs[4] = '{2'd0, {32'h01010101, 32'h00000001, 32'h00000000, 32'h01000000},
                          {32'h7c7c7c7c, 32'h7c7c425d, 32'h63636363, 32'h5d7c7c42}};
        vecs[5] = '{2'd1, {32'h6363637c, 32'h7c7c7c7c, 32'h63636363, 32'h7c636363},
                          {32'h090d0b0e, 32'h01010101, 32'h00000000, 32'h0e090d0b}};
        vecs[6] = '{2'd2, {32'hffffffff, 32'h0405060f, 32'h10111213, 32'h00010203},
                          {32'h16161616, 32'hf26b6f76, 32'hca82c97d, 32'h637c777b}};
        vecs[7] = '{2'd3, {32'h16161616, 32'hf26b6f76, 32'hca82c97d, 32'h637c777b},
                          {32'hffffffff, 32'h0405060f, 32'h10111213, 32'h00010203}};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 2'd0;
        in_data   = '0;
        out_ready = 1'b1;
        cur_exp   = '0;
`ifdef SBOX_TBOX_PIPE_ARK_EN
        in_key    = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_data", out_data, '0);
        rst = 1'b0;
        #1;
        check("reset_out_valid", W'(out_valid), W'(0));
        check("reset_in_ready", W'(in_ready), W'(1));

        // Single beats: exactly two cycles of latency, then the result.
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            #1;
            check($sformatf("vec%0d_in_ready", i), W'(in_ready), W'(1));
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check($sformatf("vec%0d_lat1_valid", i), W'(out_valid), W'(0));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_lat2_valid", i), W'(out_valid), W'(1));
            check($sformatf("vec%0d_data", i), out_data, vecs[i].dout);
        end
        @(posedge clk);
        #1;

        // 16 back-to-back beats with rotating modes: 18 cycles in, 16 out.
        exp_q.delete();
        sent = 0;
        rcvd = 0;
        for (int t = 0; t < 18; t++) begin
            if (t < 16) drive(vecs[t % 8]);
            else        in_valid = 1'b0;
            step("stream");
        end
        check("stream_sent", W'(sent), W'(16));
        check("stream_rcvd", W'(rcvd), W'(16));

        // Stall with three beats offered.
        exp_q.delete();
        sent = 0;
        rcvd = 0;
        out_ready = 1'b0;
        drive(vecs[0]);
        step("bp");
        drive(vecs[6]);
        step("bp");
        drive(vecs[5]);
        for (int k = 0; k < 5; k++) begin
            step("bp");
            check($sformatf("bp_in_ready%0d", k), W'(in_ready), W'(0));
            check($sformatf("bp_out_valid%0d", k), W'(out_valid), W'(1));
            check($sformatf("bp_hold%0d", k), out_data, vecs[0].dout);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 12 && rcvd < 3; k++) begin
            step("bp");
            if (sent == 3) in_valid = 1'b0;
        end
        check("bp_sent", W'(sent), W'(3));
        check("bp_rcvd", W'(rcvd), W'(3));

        // Reset with two beats in flight: nothing may emerge afterwards.
        exp_q.delete();
        out_ready = 1'b0;
        drive(vecs[4]);
        step("rst");
        drive(vecs[7]);
        step("rst");
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_out_data", out_data, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_out_valid", W'(out_valid), W'(0));
        check("midrst_in_ready", W'(in_ready), W'(1));
        exp_q.delete();
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step("post_rst");
            check($sformatf("post_rst_valid%0d", k), W'(out_valid), W'(0));
        end

        // Pipeline still usable after the mid-flight reset.
        sent = 0;
        rcvd = 0;
        drive(vecs[2]);
        step("after_rst");
        in_valid = 1'b0;
        for (int k = 0; k < 6 && rcvd < 1; k++) step("after_rst");
        check("after_rst_rcvd", W'(rcvd), W'(1));

`ifdef SBOX_TBOX_PIPE_ARK_EN
        sent = 0;
        rcvd = 0;
        in_key = {4{32'hffffffff}};
        drive('{2'd2, {4{32'h00000000}}, {4{32'h9c9c9c9c}}});
        step("ark");
        in_valid = 1'b0;
        in_key = '0;
        for (int k = 0; k < 6 && rcvd < 1; k++) step("ark");
        check("ark_rcvd", W'(rcvd), W'(1));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
